// File: rtl/gpu_rf_pkg.sv
// Shared constants, derived widths and bank/row mapping helpers for the banked register file.
package gpu_rf_pkg;

    localparam int unsigned DEF_LANES      = 32;
    localparam int unsigned DEF_DATA_W     = 64;
    localparam int unsigned DEF_WARPS      = 4;
    localparam int unsigned DEF_REGS       = 32;
    localparam int unsigned DEF_BANKS      = 4;
    localparam int unsigned DEF_STARVE_MAX = 2;

    // Index width that stays at least one bit for single-entry dimensions.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned WARP_W = clog2w(DEF_WARPS);
    localparam int unsigned REG_W  = clog2w(DEF_REGS);
    localparam int unsigned ROW_W  = clog2w(DEF_WARPS * DEF_REGS / DEF_BANKS);
    localparam int unsigned BANK_W = clog2w(DEF_BANKS);

    // Warp-swizzled bank: consecutive warps start on different banks.
    function automatic int unsigned bank_of(input int unsigned warp, input int unsigned reg_idx,
                                            input int unsigned banks);
        return (warp + reg_idx) % banks;
    endfunction

    // Row inside the bank: {warp, reg / BANKS}.
    function automatic int unsigned row_of(input int unsigned warp, input int unsigned reg_idx,
                                           input int unsigned regs, input int unsigned banks);
        return warp * (regs / banks) + reg_idx / banks;
    endfunction

endpackage

// File: rtl/gpu_regfile_banked_if.sv
// Read-request, read-data and writeback bundle between scheduler/writeback and the register file.
interface gpu_regfile_banked_if import gpu_rf_pkg::*; #(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned WARPS  = DEF_WARPS,
    parameter int unsigned REGS   = DEF_REGS
);
    localparam int unsigned W_W    = clog2w(WARPS);
    localparam int unsigned R_W    = clog2w(REGS);
    localparam int unsigned LINE_W = LANES * DATA_W;

    logic              rd_valid;
    logic              rd_ready;
    logic [W_W-1:0]    rd_warp;
    logic [R_W-1:0]    rd_reg;
    logic              rd_data_valid;
    logic [LINE_W-1:0] rd_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [W_W-1:0]    wr_warp;
    logic [R_W-1:0]    wr_reg;
    logic [LANES-1:0]  wr_mask;
    logic [LINE_W-1:0] wr_data;

    modport master (
        output rd_valid, rd_warp, rd_reg, wr_valid, wr_warp, wr_reg, wr_mask, wr_data,
        input  rd_ready, rd_data_valid, rd_data, wr_ready
    );

    modport slave (
        input  rd_valid, rd_warp, rd_reg, wr_valid, wr_warp, wr_reg, wr_mask, wr_data,
        output rd_ready, rd_data_valid, rd_data, wr_ready
    );

endinterface

// File: rtl/gpu_rf_bank.sv
// One single-ported bank: per-lane write enables, registered read address and registered read data.
module gpu_rf_bank import gpu_rf_pkg::*; #(
    parameter  int unsigned LANES  = DEF_LANES,
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned ROWS   = DEF_WARPS * DEF_REGS / DEF_BANKS,
    localparam int unsigned ROW_W_L = clog2w(ROWS),
    localparam int unsigned LINE_W  = LANES * DATA_W
) (
    input  logic               i_clk,
    input  logic               i_en,
    input  logic               i_we,
    input  logic [ROW_W_L-1:0] i_row,
    input  logic [LANES-1:0]   i_lane_we,
    input  logic [LINE_W-1:0]  i_wdata,
    output logic [LINE_W-1:0]  o_rdata
);

    logic [LINE_W-1:0]  r_mem [ROWS];
    logic [ROW_W_L-1:0] r_raddr;
    logic [LINE_W-1:0]  r_rdata;

    // Masked lane write; unselected lanes keep their contents.
    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (i_lane_we[i]) begin
                    r_mem[i_row][i*DATA_W +: DATA_W] <= i_wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Capture the read row when the port is granted to a read.
    always_ff @(posedge i_clk) begin
        if (i_en && !i_we) begin
            r_raddr <= i_row;
        end
    end

    // Registered array output, one cycle after the address was captured.
    always_ff @(posedge i_clk) begin
        r_rdata <= r_mem[r_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/gpu_regfile_banked.sv
// Banked SIMT register file: read/write bank arbitration with starvation guard and 2-stage read pipe.
module gpu_regfile_banked import gpu_rf_pkg::*; #(
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned WARPS      = DEF_WARPS,
    parameter int unsigned REGS       = DEF_REGS,
    parameter int unsigned BANKS      = DEF_BANKS,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    gpu_regfile_banked_if.slave  bus
);

    localparam int unsigned ROWS     = WARPS * REGS / BANKS;
    localparam int unsigned ROW_W_T  = clog2w(ROWS);
    localparam int unsigned BANK_W_T = clog2w(BANKS);
    localparam int unsigned STARVE_W = clog2w(STARVE_MAX + 1);
    localparam int unsigned LINE_W   = LANES * DATA_W;

    logic [BANK_W_T-1:0] w_rd_bank;
    logic [BANK_W_T-1:0] w_wr_bank;
    logic [ROW_W_T-1:0]  w_rd_row;
    logic [ROW_W_T-1:0]  w_wr_row;
    logic                w_conflict;
    logic                w_rd_win;
    logic                w_rd_fire;
    logic                w_wr_fire;
    logic [LINE_W-1:0]   w_bank_rdata [BANKS];

    logic [STARVE_W-1:0] r_starve;
    logic                r_p1_valid;
    logic                r_p2_valid;
    logic [BANK_W_T-1:0] r_p1_bank;
    logic [BANK_W_T-1:0] r_p2_bank;
    logic                r_rd_data_valid;
    logic [LINE_W-1:0]   r_rd_data;

    assign w_rd_bank = BANK_W_T'(bank_of(32'(bus.rd_warp), 32'(bus.rd_reg), BANKS));
    assign w_wr_bank = BANK_W_T'(bank_of(32'(bus.wr_warp), 32'(bus.wr_reg), BANKS));
    assign w_rd_row  = ROW_W_T'(row_of(32'(bus.rd_warp), 32'(bus.rd_reg), REGS, BANKS));
    assign w_wr_row  = ROW_W_T'(row_of(32'(bus.wr_warp), 32'(bus.wr_reg), REGS, BANKS));

    // Write wins a bank collision until the read has stalled STARVE_MAX times.
    assign w_conflict   = bus.rd_valid && bus.wr_valid && (w_rd_bank == w_wr_bank);
    assign w_rd_win     = (r_starve == STARVE_W'(STARVE_MAX));
    assign bus.rd_ready = !w_conflict || w_rd_win;
    assign bus.wr_ready = !w_conflict || !w_rd_win;
    assign w_rd_fire    = bus.rd_valid && bus.rd_ready;
    assign w_wr_fire    = bus.wr_valid && bus.wr_ready;

    for (genvar b = 0; b < int'(BANKS); b++) begin : g_bank
        logic               w_rd_sel;
        logic               w_wr_sel;
        logic [ROW_W_T-1:0] w_row;

        assign w_rd_sel = w_rd_fire && (w_rd_bank == BANK_W_T'(b));
        assign w_wr_sel = w_wr_fire && (w_wr_bank == BANK_W_T'(b));
        assign w_row    = w_wr_sel ? w_wr_row : w_rd_row;

        gpu_rf_bank #(
            .LANES  (LANES),
            .DATA_W (DATA_W),
            .ROWS   (ROWS)
        ) u_bank (
            .i_clk     (clk),
            .i_en      (w_rd_sel || w_wr_sel),
            .i_we      (w_wr_sel),
            .i_row     (w_row),
            .i_lane_we (bus.wr_mask),
            .i_wdata   (bus.wr_data),
            .o_rdata   (w_bank_rdata[b])
        );
    end

    // Starve counter: counts reads lost to writes, cleared by any accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_rd_fire) begin
            r_starve <= '0;
        end else if (w_conflict) begin
            r_starve <= r_starve + STARVE_W'(1);
        end
    end

    // Bank-select pipeline tracking the read through the bank's address and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p2_valid <= 1'b0;
            r_p1_bank  <= '0;
            r_p2_bank  <= '0;
        end else begin
            r_p1_valid <= w_rd_fire;
            r_p1_bank  <= w_rd_bank;
            r_p2_valid <= r_p1_valid;
            r_p2_bank  <= r_p1_bank;
        end
    end

    // Output register: selects the owning bank and holds the last data between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data_valid <= 1'b0;
            r_rd_data       <= '0;
        end else begin
            r_rd_data_valid <= r_p2_valid;
            if (r_p2_valid) begin
                r_rd_data <= w_bank_rdata[r_p2_bank];
            end
        end
    end

    assign bus.rd_data_valid = r_rd_data_valid;
    assign bus.rd_data       = r_rd_data;

endmodule

// File: doc/gpu_regfile_banked.md
Name: gpu_regfile_banked

Overview:
- Parametrised multi-warp SIMT register file: per-lane vector registers, physically split into BANKS single-ported banks.
- Uses warp-swizzled bank mapping, a 2-cycle registered read pipeline, per-lane write mask, and write/read bank-conflict arbitration with a starvation guard.
- Sits between the warp scheduler / operand collector (read requests) and the writeback stage (write requests).

Parameters:
- LANES, 32, SIMT lanes per warp (power of 2)
- DATA_W, 64, bits per lane register
- WARPS, 4, resident warps (power of 2)
- REGS, 32, architectural registers per warp (power of 2)
- BANKS, 4, physical banks (power of 2, BANKS <= REGS)
- STARVE_MAX, 2, consecutive read stalls before the read is forced to win

Ports:
- clk, in, 1, clock, all state on rising edge
- rst, in, 1, asynchronous active-high reset
- rd_valid, in, 1, read request present
- rd_ready, out, 1, read request accepted this cycle when rd_valid && rd_ready
- rd_warp, in, log2(WARPS), read warp index
- rd_reg, in, log2(REGS), read register index
- rd_data_valid, out, 1, one-cycle pulse marking rd_data valid
- rd_data, out, LANES*DATA_W, lane i at bits [i*DATA_W +: DATA_W]
- wr_valid, in, 1, write request present
- wr_ready, out, 1, write accepted when wr_valid && wr_ready
- wr_warp, in, log2(WARPS), write warp index
- wr_reg, in, log2(REGS), write register index
- wr_mask, in, LANES, per-lane write enable (bit i → lane i)
- wr_data, in, LANES*DATA_W, same packing as rd_data

Behaviour:
- Bank mapping: bank = (reg + warp) mod BANKS. Row within bank = {warp, reg / BANKS}. Each bank holds WARPS*REGS/BANKS rows of LANES*DATA_W bits.
- Reset (async, any time): rd_data_valid=0, rd_data=0, pipeline valids cleared, starve counter=0. rd_ready and wr_ready are combinational, so they follow the arbitration rules below. Array contents are not reset; a read of a never-written register returns an undefined value.
- Reset asserted mid-read drops the in-flight read; no rd_data_valid pulse is produced for it.
- Read latency: request accepted at edge N → bank read registered at N+1 → rd_data/rd_data_valid registered at N+2. Fully pipelined, one read per cycle.
- rd_data holds its last value when rd_data_valid=0. There is no output backpressure.
- Write: accepted at edge N commits at edge N. Only lanes with wr_mask[i]=1 are updated; other lanes keep their old value.
- Read accepted at N+1 or later to the same register sees the new data.
- Arbitration is combinational from the current inputs and the starve counter:
  - Different banks, or only one request valid: rd_ready=1, wr_ready=1.
  - Same bank and starve < STARVE_MAX: write wins (wr_ready=1, rd_ready=0); starve increments.
  - Same bank and starve == STARVE_MAX: read wins (rd_ready=1, wr_ready=0).
  - starve resets to 0 on any accepted read.
- Same-cycle read and write to the identical register is always a same-bank conflict, so it resolves by the rules above. There is no bypass.
- Write with wr_mask=0: accepted and consumes the bank slot, but changes no data.
- Widths: no arithmetic beyond index math; all indexes are unsigned and in range by construction (power-of-2 parameters).

Decomposition:
- Package gpu_rf_pkg holds:
  - default parameter constants
  - function bank_of(warp, reg) and row_of(warp, reg)
  - derived widths: WARP_W, REG_W, ROW_W, BANK_W
- Sub-module gpu_rf_bank: one bank, single port, per-lane write enables, registered read output, one instance per bank.
- Top level holds arbitration, the starve counter, the read-bank select pipeline register, and the output register/mux.

Test Plan:
- Basic latency: write warp1 reg5, all lanes lane_i=64'h1000+i, mask all-ones; read warp1 reg5 next cycle → rd_data_valid exactly 2 cycles after acceptance, each lane = 64'h1000+i.
- Lane mask: preload warp0 reg3 = all 64'hAA; write 64'hBB with wr_mask=32'h0000_FFFF → lanes 0-15 read 64'hBB, lanes 16-31 read 64'hAA.
- Swizzle isolation: write distinct patterns to warp0..3 reg0 (banks 0,1,2,3) → each read returns only its own warp's pattern; back-to-back reads give 4 valid pulses on consecutive cycles.
- Conflict and starvation: hold wr_valid=1 (warp0 reg4, bank0) and rd_valid=1 (warp0 reg0, bank0) continuously → rd_ready low for 2 cycles, high on the 3rd with wr_ready=0 that cycle, then the pattern repeats. Simultaneous read of a different bank → both ready=1.
- Reset mid-operation: accept a read, assert rst one cycle later → rd_data_valid never pulses and rd_data=0. After release, a previously written register still reads its stored value.
